// File: rtl/counter_hex.sv
// Up/down modulo counter with load/clear, terminal-count and wrap pulse, plus per-nibble
// seven-segment decode (active-low) that is built only when COUNTER_HEX_DISPLAY_EN is defined.
module counter_hex #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 256,
    parameter int              DIGITS  = (WIDTH + 3) / 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   hex
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    logic             run_q, run_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    // run_q swallows the first edge after reset release; the count register is the
    // second stage, so the first update lands on the second edge.
    always_comb begin
        run_d   = 1'b1;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (run_q) begin
            if (clear) begin
                count_d = '0;
            end else if (load) begin
                count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            end else if (en) begin
                if (up) begin
                    if (at_max) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (at_zero) begin
                        count_d = MAX_VAL;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q   <= 1'b0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = en & ~clear & ~load & ((up & at_max) | (~up & at_zero));

`ifdef COUNTER_HEX_DISPLAY_EN
    localparam int NIB_W = 4 * DIGITS;

    logic [NIB_W-1:0] count_ext;

    // Segment order {g,f,e,d,c,b,a}, low = lit.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    always_comb begin
        count_ext = NIB_W'(count_q);
        hex       = '1;
        for (int i = 0; i < DIGITS; i++) begin
            hex[7*i +: 7] = seg7(count_ext[4*i +: 4]);
        end
    end
`else
    assign hex = '1;
`endif

endmodule

// File: tb/tb_counter_hex.sv
// Bench for counter_hex: two instances (modulus 256 and 10, both 8 bits wide) share stimulus
// and are checked against an arithmetic reference model plus directed expectations.
module tb_counter_hex;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       clear    = 1'b0;
    logic       en       = 1'b0;
    logic       up       = 1'b1;
    logic       load     = 1'b0;
    logic [7:0] load_val = '0;

    logic [7:0]  cnt_o  [2];
    logic        tc_o   [2];
    logic        wrap_o [2];
    logic [13:0] hex_o  [2];

    always #5 clk = ~clk;

    counter_hex #(.WIDTH(8), .MODULUS(256)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .hex(hex_o[0])
    );

    counter_hex #(.WIDTH(8), .MODULUS(10)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .hex(hex_o[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int mod_v   [2] = '{256, 10};
    int m_count [2] = '{0, 0};
    bit m_wrap  [2] = '{1'b0, 1'b0};
    bit m_run       = 1'b0;

    // Lit segments, active-high, {g,f,e,d,c,b,a}
    logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef COUNTER_HEX_DISPLAY_EN
    localparam logic [13:0] HEX_00 = {7'b1000000, 7'b1000000};
    localparam logic [13:0] HEX_09 = {7'b1000000, 7'b0010000};
`else
    localparam logic [13:0] HEX_00 = '1;
    localparam logic [13:0] HEX_09 = '1;
`endif

    function automatic logic [13:0] exp_hex(input int c);
`ifdef COUNTER_HEX_DISPLAY_EN
        return {~lit[(c / 16) % 16], ~lit[c % 16]};
`else
        return 14'h3FFF;
`endif
    endfunction

    function automatic bit exp_tc(input int i);
        return en && !clear && !load &&
               ((up && m_count[i] == mod_v[i] - 1) || (!up && m_count[i] == 0));
    endfunction

    function automatic void model_step();
        if (!reset) begin
            m_count = '{0, 0};
            m_wrap  = '{1'b0, 1'b0};
            m_run   = 1'b0;
            return;
        end
        if (!m_run) begin
            m_run  = 1'b1;
            m_wrap = '{1'b0, 1'b0};
            return;
        end
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 1'b0;
            if (clear) begin
                m_count[i] = 0;
            end else if (load) begin
                m_count[i] = (int'(load_val) >= mod_v[i]) ? mod_v[i] - 1 : int'(load_val);
            end else if (en && up) begin
                m_wrap[i]  = (m_count[i] + 1 == mod_v[i]);
                m_count[i] = (m_count[i] + 1) % mod_v[i];
            end else if (en) begin
                m_wrap[i]  = (m_count[i] == 0);
                m_count[i] = (m_count[i] + mod_v[i] - 1) % mod_v[i];
            end
        end
    endfunction

    // Driver tasks
    task automatic set_in(input logic c, input logic l, input logic e, input logic u,
                          input logic [7:0] lv);
        clear = c; load = l; en = e; up = u; load_val = lv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic assert_reset();
        reset   = 1'b0;
        m_count = '{0, 0};
        m_wrap  = '{1'b0, 1'b0};
        m_run   = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 1, 8'h00);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cnt_o[i] !== 8'h00) $display("FAIL reset_count[%0d]: got %h expected 00", i, cnt_o[i]);
            else n_pass++;
            n_checks++;
            if (wrap_o[i] !== 1'b0) $display("FAIL reset_wrap[%0d]: got %b expected 0", i, wrap_o[i]);
            else n_pass++;
            n_checks++;
            if (hex_o[i] !== HEX_00) $display("FAIL reset_hex[%0d]: got %h expected %h", i, hex_o[i], HEX_00);
            else n_pass++;
            n_checks++;
            if (tc_o[i] !== 1'b0) $display("FAIL reset_tc_idle[%0d]: got %b expected 0", i, tc_o[i]);
            else n_pass++;
        end
        set_in(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (tc_o[i] !== 1'b1) $display("FAIL reset_tc_down[%0d]: got %b expected 1", i, tc_o[i]);
            else n_pass++;
        end
        set_in(0, 0, 1, 1, 8'h00);
        release_reset();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cnt_o[i] !== 8'h00) $display("FAIL release_first_edge[%0d]: got %h expected 00", i, cnt_o[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k <= 256; k++) begin
            set_in(0, 0, 1, 1, 8'h00);
            n_checks++;
            if (tc_o[0] !== (k % 256 == 255)) $display("FAIL up_tc_a k=%0d: got %b expected %b", k, tc_o[0], (k % 256 == 255));
            else n_pass++;
            n_checks++;
            if (tc_o[1] !== (k % 10 == 9)) $display("FAIL up_tc_b k=%0d: got %b expected %b", k, tc_o[1], (k % 10 == 9));
            else n_pass++;
            tick();
            n_checks++;
            if (cnt_o[0] !== 8'((k + 1) % 256)) $display("FAIL up_count_a k=%0d: got %h expected %h", k, cnt_o[0], 8'((k + 1) % 256));
            else n_pass++;
            n_checks++;
            if (wrap_o[0] !== (k == 255)) $display("FAIL up_wrap_a k=%0d: got %b expected %b", k, wrap_o[0], (k == 255));
            else n_pass++;
            n_checks++;
            if (cnt_o[1] !== 8'((k + 1) % 10)) $display("FAIL up_count_b k=%0d: got %h expected %h", k, cnt_o[1], 8'((k + 1) % 10));
            else n_pass++;
            n_checks++;
            if (wrap_o[1] !== (k % 10 == 9)) $display("FAIL up_wrap_b k=%0d: got %b expected %b", k, wrap_o[1], (k % 10 == 9));
            else n_pass++;
        end
    endtask

    task automatic test_down_wrap();
        set_in(1, 0, 1, 1, 8'h00);
        tick();
        set_in(0, 0, 1, 0, 8'h00);
        n_checks++;
        if (tc_o[1] !== 1'b1) $display("FAIL down_tc_b: got %b expected 1", tc_o[1]);
        else n_pass++;
        tick();
        n_checks++;
        if (cnt_o[1] !== 8'd9) $display("FAIL down_count_b: got %h expected 09", cnt_o[1]);
        else n_pass++;
        n_checks++;
        if (cnt_o[0] !== 8'hFF) $display("FAIL down_count_a: got %h expected ff", cnt_o[0]);
        else n_pass++;
        n_checks++;
        if (wrap_o[1] !== 1'b1 || wrap_o[0] !== 1'b1) $display("FAIL down_wrap: got %b%b expected 11", wrap_o[0], wrap_o[1]);
        else n_pass++;
        n_checks++;
        if (hex_o[1] !== HEX_09) $display("FAIL down_hex_b: got %h expected %h", hex_o[1], HEX_09);
        else n_pass++;
        set_in(0, 0, 0, 0, 8'h00);
        tick();
        n_checks++;
        if (wrap_o[1] !== 1'b0 || cnt_o[1] !== 8'd9) $display("FAIL down_hold_b: got wrap %b count %h expected 0/09", wrap_o[1], cnt_o[1]);
        else n_pass++;
    endtask

    task automatic test_load();
        logic [7:0] lv_tab [5] = '{8'd14, 8'd10, 8'd9, 8'd0, 8'd255};
        for (int j = 0; j < 5; j++) begin
            set_in(0, 1, j[0], 1, lv_tab[j]);
            n_checks++;
            if (tc_o[0] !== 1'b0 || tc_o[1] !== 1'b0) $display("FAIL load_tc j=%0d: got %b%b expected 00", j, tc_o[0], tc_o[1]);
            else n_pass++;
            tick();
            n_checks++;
            if (cnt_o[0] !== lv_tab[j]) $display("FAIL load_a j=%0d: got %h expected %h", j, cnt_o[0], lv_tab[j]);
            else n_pass++;
            n_checks++;
            if (cnt_o[1] !== ((lv_tab[j] > 8'd9) ? 8'd9 : lv_tab[j])) $display("FAIL load_b j=%0d: got %h expected %h", j, cnt_o[1], (lv_tab[j] > 8'd9) ? 8'd9 : lv_tab[j]);
            else n_pass++;
            n_checks++;
            if (wrap_o[0] !== 1'b0 || wrap_o[1] !== 1'b0) $display("FAIL load_wrap j=%0d: got %b%b expected 00", j, wrap_o[0], wrap_o[1]);
            else n_pass++;
        end
    endtask

    task automatic test_clear_priority();
        set_in(0, 1, 0, 1, 8'd5);
        tick();
        set_in(1, 1, 1, 1, 8'd5);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cnt_o[i] !== 8'h00 || wrap_o[i] !== 1'b0) $display("FAIL clear_prio[%0d]: got %h/%b expected 00/0", i, cnt_o[i], wrap_o[i]);
            else n_pass++;
        end
        set_in(0, 1, 0, 1, 8'd9);
        tick();
        set_in(1, 0, 1, 1, 8'd0);
        tick();
        n_checks++;
        if (cnt_o[1] !== 8'h00 || wrap_o[1] !== 1'b0) $display("FAIL clear_at_tc_b: got %h/%b expected 00/0", cnt_o[1], wrap_o[1]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        set_in(0, 1, 0, 1, 8'hA7);
        tick();
        n_checks++;
        if (hex_o[0] !== exp_hex(8'hA7) || cnt_o[0] !== 8'hA7) $display("FAIL a7_load: got %h/%h expected a7/%h", cnt_o[0], hex_o[0], exp_hex(8'hA7));
        else n_pass++;
        set_in(0, 0, 1, 1, 8'h00);
        tick();
        n_checks++;
        if (wrap_o[1] !== 1'b1 || cnt_o[0] !== 8'hA8) $display("FAIL pre_reset: got wrap_b %b count_a %h expected 1/a8", wrap_o[1], cnt_o[0]);
        else n_pass++;
        assert_reset();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cnt_o[i] !== 8'h00 || wrap_o[i] !== 1'b0 || hex_o[i] !== HEX_00) $display("FAIL async_reset[%0d]: got %h/%b/%h expected 00/0/%h", i, cnt_o[i], wrap_o[i], hex_o[i], HEX_00);
            else n_pass++;
        end
        release_reset();
        tick();
        n_checks++;
        if (cnt_o[0] !== 8'h00 || wrap_o[1] !== 1'b0) $display("FAIL post_release_edge1: got %h/%b expected 00/0", cnt_o[0], wrap_o[1]);
        else n_pass++;
        tick();
        n_checks++;
        if (cnt_o[0] !== 8'h01 || wrap_o[1] !== 1'b0) $display("FAIL post_release_edge2: got %h/%b expected 01/0", cnt_o[0], wrap_o[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                assert_reset();
                for (int i = 0; i < 2; i++) begin
                    n_checks++;
                    if (cnt_o[i] !== 8'h00 || wrap_o[i] !== 1'b0) $display("FAIL rnd_reset[%0d] n=%0d: got %h/%b expected 00/0", i, n, cnt_o[i], wrap_o[i]);
                    else n_pass++;
                end
                release_reset();
            end
            set_in($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (tc_o[i] !== exp_tc(i)) $display("FAIL rnd_tc[%0d] n=%0d: got %b expected %b", i, n, tc_o[i], exp_tc(i));
                else n_pass++;
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (cnt_o[i] !== 8'(m_count[i])) $display("FAIL rnd_count[%0d] n=%0d: got %h expected %h", i, n, cnt_o[i], 8'(m_count[i]));
                else n_pass++;
                n_checks++;
                if (wrap_o[i] !== m_wrap[i]) $display("FAIL rnd_wrap[%0d] n=%0d: got %b expected %b", i, n, wrap_o[i], m_wrap[i]);
                else n_pass++;
                n_checks++;
                if (hex_o[i] !== exp_hex(m_count[i])) $display("FAIL rnd_hex[%0d] n=%0d: got %h expected %h", i, n, hex_o[i], exp_hex(m_count[i]));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_wrap();
        test_down_wrap();
        test_load();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
